mdu_iterative: RTL

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, for the next-generation MIPS datapath.
- Adds MULT/MULTU/DIV/DIVU plus MTHI/MTLO support, which the single-cycle core lacks.
- The datapath issues an operation and then stalls on Busy before any MFHI/MFLO or before issuing a new MDU operation.
- Radix-2 iterative: one bit per cycle, fixed latency independent of operand values.

---
 rtl/mdu_iterative_pkg.sv | 50 +++++
 rtl/mdu_iterative.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative_pkg.sv
// Shared multiply/divide unit definitions: op and state encodings plus the
// funct decode used by the control unit to drive the MDU.
package mdu_defs;

    localparam int unsigned FUNCT_W = 6;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;
    localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'h1A;
    localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'h1B;

    typedef struct packed {
        logic    start;
        mdu_op_e op;
        logic    mthi;
        logic    mtlo;
    } mdu_ctrl_t;

    // R-type funct field to MDU control strobes
    function automatic mdu_ctrl_t mdu_decode(input logic [FUNCT_W-1:0] funct);
        mdu_ctrl_t c;
        c = '0;
        case (funct)
            FUNCT_MULT:  begin c.start = 1'b1; c.op = MDU_MULT;  end
            FUNCT_MULTU: begin c.start = 1'b1; c.op = MDU_MULTU; end
            FUNCT_DIV:   begin c.start = 1'b1; c.op = MDU_DIV;   end
            FUNCT_DIVU:  begin c.start = 1'b1; c.op = MDU_DIVU;  end
            FUNCT_MTHI:  c.mthi = 1'b1;
            FUNCT_MTLO:  c.mtlo = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Radix-2 iterative multiply/divide unit with HI/LO registers.
// Fixed latency: WIDTH CALC steps followed by one sign-fixup/writeback cycle.
module mdu_iterative
    import mdu_defs::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Mthi,
    input  logic             Mtlo,
    input  logic [WIDTH-1:0] Wr_Data,
    output logic             Busy,
    output logic             Done,
    output logic             Div_By_Zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         state_q, state_d;
    mdu_op_e            op_q, op_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               bzero_q, bzero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Operand capture: magnitudes and sign flags for the signed ops
    mdu_op_e          op_in;
    logic             signed_in;
    logic             a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_in     = mdu_op_e'(Op);
    assign signed_in = (op_in == MDU_MULT) || (op_in == MDU_DIV);
    assign a_sgn     = signed_in & Operand_A[WIDTH-1];
    assign b_sgn     = signed_in & Operand_B[WIDTH-1];
    assign a_mag     = a_sgn ? -Operand_A : Operand_A;
    assign b_mag     = b_sgn ? -Operand_B : Operand_B;

    // One iteration step of each algorithm on the {acc, sh} pair
    logic             op_is_div;
    logic [WIDTH:0]   mult_sum;
    logic [WIDTH:0]   div_tmp;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign op_is_div = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    assign mult_sum  = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
    assign div_tmp   = {acc_q, sh_q[WIDTH-1]};
    assign div_ge    = (div_tmp >= {1'b0, b_q});
    assign div_diff  = div_tmp[WIDTH-1:0] - b_q;

    // Final sign correction of product, quotient and remainder
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign prod_raw = {acc_q, sh_q};
    assign prod_fix = neg_q ? -prod_raw : prod_raw;
    assign quo_fix  = neg_q ? -sh_q : sh_q;
    assign rem_fix  = rem_neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_raw_d   = a_raw_q;
        b_d       = b_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d      = op_in;
                    a_raw_d   = Operand_A;
                    b_d       = b_mag;
                    acc_d     = '0;
                    sh_d      = a_mag;
                    cnt_d     = CNT_W'(WIDTH);
                    rem_neg_d = a_sgn;
                    bzero_d   = (Operand_B == '0);
                    if (op_in == MDU_MULT || op_in == MDU_MULTU)
                        neg_d = (a_sgn ^ b_sgn) && (Operand_A != '0) && (Operand_B != '0);
                    else
                        neg_d = a_sgn ^ b_sgn;
                    state_d   = S_CALC;
                end else begin
                    if (Mthi) hi_d = Wr_Data;
                    if (Mtlo) lo_d = Wr_Data;
                end
            end
            S_CALC: begin
                if (op_is_div) begin
                    acc_d = div_ge ? div_diff : div_tmp[WIDTH-1:0];
                    sh_d  = {sh_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = mult_sum[WIDTH:1];
                    sh_d  = {mult_sum[0], sh_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!op_is_div) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (bzero_q) begin
                    hi_d  = a_raw_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= MDU_MULT;
            a_raw_q   <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            sh_q      <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_raw_q   <= a_raw_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Div_By_Zero = dbz_q;
    assign Hi          = hi_q;
    assign Lo          = lo_q;

endmodule
